// File: rtl/bus_decoder_if.sv
// -----------------------------------------------------------------------------
// bus_decoder_if
// Bundles the CPU data-port request/response signals together with the
// decoded slave strobes and the packed slave read-data return path.
//
//   m_addr   CPU address                      (CPU -> decoder)
//   m_wdata  CPU write data                   (CPU -> decoder)
//   m_we     CPU write request                (CPU -> decoder)
//   m_re     CPU read request                 (CPU -> decoder)
//   m_rdata  read data returned to the CPU    (decoder -> CPU)
//   m_ready  transaction completes this cycle (decoder -> CPU)
//   s_wdata  write data broadcast to slaves   (decoder -> slaves)
//   s_we     one-hot slave write strobes      (decoder -> slaves)
//   s_re     one-hot slave read strobes       (decoder -> slaves)
//   s_rdata  packed slave read data           (slaves -> decoder)
//
// modport master : the CPU plus slave side that surrounds the decoder
// modport slave  : the decoder itself
// -----------------------------------------------------------------------------
interface bus_decoder_if #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
);
    logic [ADDR_W-1:0]             m_addr;
    logic [DATA_W-1:0]             m_wdata;
    logic                          m_we;
    logic                          m_re;
    logic [DATA_W-1:0]             m_rdata;
    logic                          m_ready;
    logic [DATA_W-1:0]             s_wdata;
    logic [NUM_REGIONS-1:0]        s_we;
    logic [NUM_REGIONS-1:0]        s_re;
    logic [NUM_REGIONS*DATA_W-1:0] s_rdata;

    modport master (
        output m_addr, m_wdata, m_we, m_re, s_rdata,
        input  m_rdata, m_ready, s_wdata, s_we, s_re
    );

    modport slave (
        input  m_addr, m_wdata, m_we, m_re, s_rdata,
        output m_rdata, m_ready, s_wdata, s_we, s_re
    );
endinterface

// File: rtl/bus_decoder.sv
// -----------------------------------------------------------------------------
// bus_decoder
// Data-bus address decoder and read-return router. Decodes the CPU address
// into NUM_REGIONS configurable windows, issues one-cycle slave strobes,
// inserts per-region wait states, rejects writes to read-only windows, steers
// the one-cycle-latency slave read data back to the CPU and keeps a sticky
// bus-error flag with the address of the first fault.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst       synchronous active-high reset
//   bus       bus_decoder_if.slave (CPU request/response + slave strobes/data)
//   err       sticky bus error
//   err_addr  address of the first error since the last clear
//   err_clr   clears err and err_addr (a simultaneous new error wins)
// -----------------------------------------------------------------------------
module bus_decoder #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {16'h3000, 16'h2000, 16'h1000, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {16'h30FF, 16'h2960, 16'h10FF, 16'h07FF},
    parameter logic [NUM_REGIONS*2-1:0]      REGION_WAIT  = {2'd2, 2'd0, 2'd0, 2'd0},
    parameter logic [NUM_REGIONS-1:0]        REGION_RO    = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    bus_decoder_if.slave      bus,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              err_clr
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    // The accept cycle is the IDLE cycle in which a request is present; only
    // multi-cycle accesses leave IDLE.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    rd_sel_q, rd_sel_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_fresh_q, rd_fresh_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic                   hit_s;
    logic [IDX_W-1:0]       hit_idx_s;
    logic [NUM_REGIONS-1:0] hit_onehot_s;
    logic [1:0]             hit_wait_s;
    logic                   hit_ro_s;
    logic                   req_s;
    logic                   bus_err_s;
    logic                   accept_s;
    logic [NUM_REGIONS-1:0] s_we_s;
    logic [NUM_REGIONS-1:0] s_re_s;
    logic                   m_ready_s;
    logic [DATA_W-1:0]      sel_rdata_s;
    logic [DATA_W-1:0]      m_rdata_s;

    // Window decode: scanning from the top index down lets the lowest matching
    // index overwrite higher ones, so overlaps resolve to the lowest window.
    always_comb begin
        hit_s        = 1'b0;
        hit_idx_s    = {IDX_W{1'b0}};
        hit_onehot_s = {NUM_REGIONS{1'b0}};
        hit_wait_s   = 2'd0;
        hit_ro_s     = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((bus.m_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
                (bus.m_addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W])) begin
                hit_s        = 1'b1;
                hit_idx_s    = IDX_W'(i);
                hit_onehot_s = {NUM_REGIONS{1'b0}};
                hit_onehot_s[i] = 1'b1;
                hit_wait_s   = REGION_WAIT[i*2 +: 2];
                hit_ro_s     = REGION_RO[i];
            end else begin
                hit_s        = hit_s;
            end
        end
    end

    // Request classification: a miss, a simultaneous read+write, or a write to
    // a read-only window completes at once without touching any slave.
    always_comb begin
        req_s     = bus.m_we | bus.m_re;
        bus_err_s = req_s & (~hit_s | (bus.m_we & bus.m_re) | (bus.m_we & hit_ro_s));
    end

    // FSM next state, strobes and handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_we_s    = {NUM_REGIONS{1'b0}};
        s_re_s    = {NUM_REGIONS{1'b0}};
        m_ready_s = 1'b0;
        accept_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    accept_s = 1'b1;
                    if (bus_err_s) begin
                        m_ready_s = 1'b1;
                    end else begin
                        if (bus.m_we) begin
                            s_we_s = hit_onehot_s;
                        end else begin
                            s_re_s = hit_onehot_s;
                        end
                        if (hit_wait_s == 2'd0) begin
                            m_ready_s = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = hit_wait_s - 2'd1;
                        end
                    end
                end else begin
                    m_ready_s = 1'b0;
                end
            end
            ST_WAIT: begin
                // Request inputs are deliberately not looked at here.
                if (cnt_q == 2'd0) begin
                    m_ready_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Pick the slave lane recorded at the last read accept.
    always_comb begin
        sel_rdata_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (rd_sel_q == IDX_W'(i)) begin
                sel_rdata_s = bus.s_rdata[i*DATA_W +: DATA_W];
            end else begin
                sel_rdata_s = sel_rdata_s;
            end
        end
    end

    // Read return: the slave lane is live in the cycle after the accept (slaves
    // answer one cycle after their strobe); afterwards the captured copy is
    // shown so data stays stable through any wait states and beyond.
    always_comb begin
        if (rd_fresh_q) begin
            m_rdata_s = rd_valid_q ? sel_rdata_s : {DATA_W{1'b0}};
        end else begin
            m_rdata_s = hold_q;
        end
    end

    // Read-steering and error-latch next state.
    always_comb begin
        rd_sel_d   = rd_sel_q;
        rd_valid_d = rd_valid_q;
        rd_fresh_d = 1'b0;
        hold_d     = hold_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        if (rd_fresh_q) begin
            hold_d = m_rdata_s;
        end else begin
            hold_d = hold_q;
        end

        if (accept_s && bus.m_re) begin
            rd_fresh_d = 1'b1;
            rd_valid_d = ~bus_err_s;
            rd_sel_d   = bus_err_s ? rd_sel_q : hit_idx_s;
        end else begin
            rd_fresh_d = 1'b0;
        end

        // A new error outranks a clear issued in the same cycle.
        if (accept_s && bus_err_s) begin
            err_d      = 1'b1;
            err_addr_d = (!err_q || err_clr) ? bus.m_addr : err_addr_q;
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_addr_d = {ADDR_W{1'b0}};
        end else begin
            err_d      = err_q;
            err_addr_d = err_addr_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            rd_sel_q   <= {IDX_W{1'b0}};
            rd_valid_q <= 1'b0;
            rd_fresh_q <= 1'b0;
            hold_q     <= {DATA_W{1'b0}};
            err_q      <= 1'b0;
            err_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_sel_q   <= rd_sel_d;
            rd_valid_q <= rd_valid_d;
            rd_fresh_q <= rd_fresh_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // While in reset no slave may be strobed and the master is released.
    always_comb begin
        bus.s_we    = rst ? {NUM_REGIONS{1'b0}} : s_we_s;
        bus.s_re    = rst ? {NUM_REGIONS{1'b0}} : s_re_s;
        bus.m_ready = rst | m_ready_s;
        bus.s_wdata = bus.m_wdata;
        bus.m_rdata = m_rdata_s;
        err         = err_q;
        err_addr    = err_addr_q;
    end

endmodule

// File: tb/tb_bus_decoder.sv
// -----------------------------------------------------------------------------
// tb_bus_decoder
// Scoreboard bench for bus_decoder. The driver computes each transaction's
// expected outcome from the address map and a byte-per-address memory model,
// queues it and drives the request; a negedge monitor pops expectations on
// every accept and checks strobes, handshake latency, read return and the
// sticky error state.
// -----------------------------------------------------------------------------
module tb_bus_decoder;
    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam logic [NR-1:0] RO_CFG = 4'b0100;

    typedef struct {
        logic [AW-1:0] addr;
        logic [NR-1:0] we_oh;
        logic [NR-1:0] re_oh;
        logic          is_rd;
        logic          is_err;
        int            w;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          err_clr = 1'b0;
    logic          err;
    logic [AW-1:0] err_addr;

    bus_decoder_if #(.NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_decoder #(
        .NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW), .REGION_RO(RO_CFG)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .err(err), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Address map as the bench understands it.
    int ref_base [NR] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
    int ref_lim  [NR] = '{32'h07FF, 32'h10FF, 32'h2960, 32'h30FF};
    int ref_wait [NR] = '{0, 0, 0, 2};
    int ref_ro   [NR] = '{0, 0, 1, 0};
    int gaps     [6]  = '{32'h0800, 32'h1100, 32'h2961, 32'hFFFF, 32'h0FFF, 32'h3100};

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] slv_mem [logic [AW-1:0]];
    logic [DW-1:0] srd [NR];

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    // Slave models: synchronous read, data appears the cycle after the strobe.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (bus.s_re[i])
                srd[i] <= slv_mem.exists(bus.m_addr) ? slv_mem[bus.m_addr] : (bus.m_addr[7:0] ^ 8'h5A);
            if (bus.s_we[i])
                slv_mem[bus.m_addr] = bus.s_wdata;
        end
    end
    assign bus.s_rdata = {srd[3], srd[2], srd[1], srd[0]};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference outcome of one request.
    function automatic exp_t model(input logic [AW-1:0] a, input logic we, input logic re,
                                   input logic [DW-1:0] wd);
        exp_t e;
        int   idx = -1;
        for (int i = 0; i < NR; i++)
            if (idx < 0 && int'(a) >= ref_base[i] && int'(a) <= ref_lim[i]) idx = i;
        e.addr   = a;
        e.we_oh  = '0;
        e.re_oh  = '0;
        e.is_rd  = re;
        e.w      = 0;
        e.rdata  = '0;
        e.is_err = (idx < 0) || (we && re) || (we && idx >= 0 && ref_ro[idx] != 0);
        if (!e.is_err) begin
            e.w = ref_wait[idx];
            if (we) begin
                e.we_oh[idx] = 1'b1;
                ref_mem[a]   = wd;
            end else begin
                e.re_oh[idx] = 1'b1;
                e.rdata      = ref_mem.exists(a) ? ref_mem[a] : (a[7:0] ^ 8'h5A);
            end
        end
        return e;
    endfunction

    // Monitor / scoreboard.
    logic          busy = 1'b0;
    int            lat = 0;
    exp_t          cur;
    logic [DW-1:0] exp_rd = '0;
    logic [DW-1:0] nxt_rd;
    logic          exp_err = 1'b0;
    logic [AW-1:0] exp_err_addr = '0;
    logic          acc_err;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", {31'd0, bus.m_ready}, 32'd1);
            chk("rst_s_we", {28'd0, bus.s_we}, 32'd0);
            chk("rst_s_re", {28'd0, bus.s_re}, 32'd0);
            busy = 1'b0; exp_rd = '0; exp_err = 1'b0; exp_err_addr = '0;
        end else begin
            chk("m_rdata", {24'd0, bus.m_rdata}, {24'd0, exp_rd});
            chk("err", {31'd0, err}, {31'd0, exp_err});
            chk("err_addr", {16'd0, err_addr}, {16'd0, exp_err_addr});
            nxt_rd  = exp_rd;
            acc_err = 1'b0;
            if (busy) begin
                chk("wait_s_we", {28'd0, bus.s_we}, 32'd0);
                chk("wait_s_re", {28'd0, bus.s_re}, 32'd0);
                lat++;
                if (bus.m_ready) begin
                    chk("latency", lat, cur.w);
                    busy = 1'b0;
                end else if (lat > 4) begin
                    chk("ready_timeout", 32'd0, 32'd1);
                    busy = 1'b0;
                end
            end else if (bus.m_we || bus.m_re) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("accept_addr", {16'd0, bus.m_addr}, {16'd0, cur.addr});
                    chk("s_we", {28'd0, bus.s_we}, {28'd0, cur.we_oh});
                    chk("s_re", {28'd0, bus.s_re}, {28'd0, cur.re_oh});
                    chk("ready_T", {31'd0, bus.m_ready}, {31'd0, (cur.w == 0)});
                    if (cur.is_rd) nxt_rd = cur.rdata;
                    acc_err = cur.is_err;
                    if (!bus.m_ready) begin
                        busy = 1'b1;
                        lat  = 0;
                    end
                end
            end else begin
                chk("idle_s_we", {28'd0, bus.s_we}, 32'd0);
                chk("idle_s_re", {28'd0, bus.s_re}, 32'd0);
            end
            if (acc_err) begin
                exp_err_addr = (!exp_err || err_clr) ? cur.addr : exp_err_addr;
                exp_err      = 1'b1;
            end else if (err_clr) begin
                exp_err      = 1'b0;
                exp_err_addr = '0;
            end
            exp_rd = nxt_rd;
        end
    end

    // Issue one request and hold it until the decoder reports completion.
    task automatic issue(input logic [AW-1:0] a, input logic we, input logic re,
                         input logic [DW-1:0] wd, input logic clr);
        exp_t e;
        int   n;
        e = model(a, we, re, wd);
        @(posedge clk); #1;
        exp_q.push_back(e);
        bus.m_addr = a; bus.m_we = we; bus.m_re = re; bus.m_wdata = wd; err_clr = clr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_ready && n < 8);
        if (!bus.m_ready) begin
            checks++;
            errors++;
            $display("FAIL driver_timeout addr=%0h ready=0 required=1", a);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus.m_we = 1'b0; bus.m_re = 1'b0; err_clr = 1'b0;
        end
    endtask

    task automatic clear_err();
        @(posedge clk); #1;
        bus.m_we = 1'b0; bus.m_re = 1'b0; err_clr = 1'b1;
        idle(1);
    endtask

    // Reset asserted in the first wait cycle of a W=2 read.
    task automatic reset_in_wait();
        exp_q.push_back(model(16'h3004, 1'b0, 1'b1, 8'h00));
        @(posedge clk); #1;
        bus.m_addr = 16'h3004; bus.m_we = 1'b0; bus.m_re = 1'b1; err_clr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.m_re = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            k, kind;
        bus.m_addr = '0; bus.m_wdata = '0; bus.m_we = 1'b0; bus.m_re = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        issue(16'h0010, 1'b1, 1'b0, 8'hA5, 1'b0);
        issue(16'h0010, 1'b0, 1'b1, 8'h00, 1'b0);
        idle(3);
        issue(16'h3004, 1'b0, 1'b1, 8'h00, 1'b0);
        issue(16'h0020, 1'b1, 1'b0, 8'h3C, 1'b0);
        idle(1);
        issue(16'h0800, 1'b1, 1'b0, 8'h11, 1'b0);
        idle(1);
        issue(16'hFFFF, 1'b0, 1'b1, 8'h00, 1'b0);
        idle(2);
        issue(16'h1100, 1'b0, 1'b1, 8'h00, 1'b1);
        idle(1);
        clear_err();
        idle(1);
        issue(16'h2000, 1'b1, 1'b0, 8'h77, 1'b0);
        issue(16'h2000, 1'b0, 1'b1, 8'h00, 1'b0);
        idle(2);
        reset_in_wait();
        issue(16'h0010, 1'b0, 1'b1, 8'h00, 1'b0);
        idle(2);

        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, NR - 1);
            case ($urandom_range(0, 7))
                0:       a = AW'(gaps[$urandom_range(0, 5)]);
                1:       a = AW'(ref_lim[k]);
                2:       a = AW'(ref_base[k]);
                default: a = AW'(ref_base[k] + int'($urandom_range(0, 15)));
            endcase
            kind = $urandom_range(0, 9);
            issue(a, kind <= 3 || kind == 9, kind >= 4, 8'($urandom),
                  $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_decoder.md
# bus_decoder

Parametrised data-bus address decoder and read-return router that sits between the CPU data port and the memory-mapped slaves (data RAM, I/O block, video RAM, spares). It replaces fixed-window combinational decoding with NUM_REGIONS configurable windows. It adds per-region wait states with a ready handshake, read-only protection, and registered read-data steering that matches the one-cycle synchronous read latency of the slaves. It also provides a sticky bus-error flag with fault-address capture.

## Interface
- NUM_REGIONS, 4, number of decoded windows (1..8).
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- REGION_BASE, {16'h3000,16'h2000,16'h1000,16'h0000}, packed inclusive lower bounds; region i occupies [i*ADDR_W +: ADDR_W].
- REGION_LIMIT, {16'h30FF,16'h2960,16'h10FF,16'h07FF}, packed inclusive upper bounds, same packing.
- REGION_WAIT, {2'd2,2'd0,2'd0,2'd0}, packed 2-bit wait-state count per region (0..3).
- REGION_RO, 4'b0000, bit i set: writes to region i are errors.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_addr  in  ADDR_W  master address.
- m_wdata  in  DATA_W  master write data, forwarded unregistered as s_wdata.
- m_we  in  1  master write request.
- m_re  in  1  master read request.
- m_rdata  out  DATA_W  read data to master.
- m_ready  out  1  transaction completes this cycle.
- s_wdata  out  DATA_W  write data to all slaves.
- s_we  out  NUM_REGIONS  one-hot slave write strobe.
- s_re  out  NUM_REGIONS  one-hot slave read strobe.
- s_rdata  in  NUM_REGIONS*DATA_W  packed slave read data, 1-cycle synchronous read.
- err  out  1  sticky bus error.
- err_addr  out  ADDR_W  address of first error since last clear.
- err_clr  in  1  clears err and err_addr.

## Operation
- Request present when m_we|m_re. Hit on region i when REGION_BASE[i] <= m_addr <= REGION_LIMIT[i]. Overlapping windows are resolved by lowest index.
- Error conditions:
  - no hit;
  - m_we & m_re together;
  - m_we to a region with its REGION_RO bit set.
- On error: no strobe, m_ready=1 in the same cycle, and a read returns 0.
- FSM states:
  - IDLE → ACCEPT when a request arrives.
  - Accept cycle T: the selected s_we/s_re bit is high for exactly cycle T.
  - Wait state W = REGION_WAIT[i]. W=0: m_ready=1 at T, stay IDLE. W>0: m_ready=0 at T; go to WAIT with counter=W-1.
  - WAIT: no strobes. m_ready=0 while counter>0, decrementing each cycle. m_ready=1 when counter==0, then → IDLE.
  - Master holds m_addr/m_we/m_re/m_wdata stable while m_ready=0. Request inputs are ignored in WAIT.
- Read steering:
  - Region index registered at read accept into rd_sel, with rd_valid=1.
  - Cycle T+1: m_rdata = s_rdata[rd_sel] combinationally, and is captured into a hold register on that edge.
  - From T+2 until the next read accept: m_rdata = hold register.
  - Error reads set rd_valid=0, and m_rdata = 0 from T+1.
- Error latch:
  - On an error at T, err=1 from T+1.
  - err_addr captures m_addr only if err was 0; otherwise the first fault is retained.
  - err_clr alone clears both at the next edge.
  - err_clr together with a new error: the new error wins (err=1, err_addr=new address).

## Timing
- Reset values: FSM=IDLE, counter=0, rd_valid=0, hold=0, m_rdata=0, err=0, err_addr=0.
- While rst=1: s_we=s_re=0, m_ready=1.
- Reset in WAIT aborts the transaction; no further strobe is issued.
- Write latency: strobe at T, done at T+W.
- Read data is valid at T+1 regardless of W, and stable through completion.
- Back-to-back zero-wait requests are accepted every cycle. After a wait-state transaction, the next accept is at T+W+1.
- Address wrap: 16'hFFFF with no covering region is an error; there is no modular wrap in bound compare.

## Test plan
- Write 8'hA5 to 16'h0010, read back → s_we[0] pulses 1 cycle, m_ready=1 same cycle; read: s_re[0] at T, m_rdata=8'hA5 at T+1 and held at T+2..
- Read 16'h3004 (W=2) → s_re[3] only at T, m_ready=0 at T,T+1, 1 at T+2, m_rdata valid from T+1; next request at T+3 is accepted.
- Write 16'h0800 (gap) → no strobes, m_ready=1, err=1 at T+1, err_addr=16'h0800; a second error to 16'hFFFF leaves err_addr=16'h0800.
- err_clr asserted together with an error to 16'h1100 → err stays 1, err_addr=16'h1100; err_clr alone → err=0, err_addr=0 next cycle.
- Override REGION_RO=4'b0100, write 16'h2000 → no s_we, err set; read 16'h2000 → s_re[2] pulses normally.
- Assert rst at T+1 of a W=2 access → s_re stays 0, m_ready=1, all outputs at reset values next cycle, FSM in IDLE.
